cc_register_bank: RTL and testbench
===================================

# cc_register_bank

Parametrised, synchronous control-register bank for the ChronoCube MPU bus. It generalises the fixed-address register file to NUM_REGS registers of DATA_WIDTH bits, with per-byte enables, per-register read-only and double-buffered (shadowed) behaviour, and a registered request/acknowledge bus handshake on the system clock. It sits between the MPU bus interface and the video/display logic. Shadowed registers change their live value only at a frame-boundary commit strobe, so scroll offsets and mode bits never tear mid-frame.

## Interface
- NUM_REGS, 16: number of registers; address space 0..NUM_REGS-1.
- ADDR_WIDTH, 8: bus address width.
- DATA_WIDTH, 16: register and bus width; must be a multiple of 8.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from hw_values.
- SHADOW_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i double-buffered.
- RESET_VALUE, 0: NUM_REGS*DATA_WIDTH flat vector of per-register reset values.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  access request.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- be  in  DATA_WIDTH/8  byte enables; be[k] covers bits 8k+7:8k.
- addr  in  ADDR_WIDTH  register index.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  registered read data.
- data_oe  out  1  bus-drive enable for data_out.
- ack  out  1  one-cycle access acknowledge.
- commit  in  1  frame-boundary strobe that copies staging to live.
- hw_values  in  NUM_REGS*DATA_WIDTH  read-only sources; slice i feeds register i.
- values  out  NUM_REGS*DATA_WIDTH  live register values for the system.
- write_strobe  out  NUM_REGS  one-cycle pulse per register written.

## Operation
- FSM states: IDLE, ACK, RELEASE.
  - IDLE → ACK when en & (rd | wr). The access is performed on that edge.
  - ACK → RELEASE unconditionally. ack=1 only in ACK.
  - RELEASE → IDLE when en=0. This guarantees one access per request assertion.
- Write (wr=1, rd=0, addr<NUM_REGS, RO_MASK[addr]=0):
  - Each byte with be[k]=1 is updated; other bytes hold.
  - The target is the staging register if SHADOW_MASK[addr]=1, otherwise the live register.
  - write_strobe[addr] pulses in the ACK cycle.
- Read (rd=1, wr=0):
  - data_out is loaded on the accept edge.
  - It takes the live value, or the hw_values slice if RO_MASK[addr]=1; shadowed registers return the staging value.
  - data_oe=1 in ACK and RELEASE.
- rd and wr both high: no write, data_out=0, ack still given.
- addr ≥ NUM_REGS: writes ignored, reads return 0, ack given, no write_strobe.
- Writes to read-only registers: ignored, acked, no strobe.
- commit=1: every shadowed live register is loaded from its staging register on that edge.
- Write and commit on the same edge: the live value takes the newly merged staging data, so the write is not lost and not delayed a frame.
- values: live registers, with RO slices passing hw_values straight through.

## Timing
- Reset (reset=0, async):
  - live and staging registers = RESET_VALUE.
  - data_out=0, data_oe=0, ack=0, write_strobe=0, FSM=IDLE.
- A request held high across the reset release is accepted on the first clock edge after release.
- Read latency: data_out is valid, and ack=1, one cycle after the accept edge.
- Write visible on values: the cycle after accept for non-shadowed registers; the cycle after commit for shadowed registers.
- Minimum access spacing is 3 cycles: accept, ACK, RELEASE with en low.

## Configuration
- CC_REG_SHADOW_EN defined: staging registers and commit logic are built as described.
- Not defined:
  - SHADOW_MASK is ignored and commit is unused.
  - All writable registers write live directly.
  - Reads return live values.
  - No staging flops are synthesised.

## Structure
- The shared package cc_regs_pkg holds:
  - FSM state encoding.
  - Register address constants (MAIN_CTRL, X_POS, Y_POS, X_OFFSET, Y_OFFSET).
  - Default RO_MASK and SHADOW_MASK for the display configuration.
- Sub-module cc_byte_reg: one DATA_WIDTH register with per-byte enable and an async active-low reset to a parameter value. It is instantiated for live and staging copies.

## Test plan
- Reset then read addr 0 with RESET_VALUE slice 0=16'h0003 → ack one cycle after accept, data_out=16'h0003, data_oe high in ACK and RELEASE.
- Write 16'hABCD with be=2'b01 to non-shadowed reg 3 holding 16'h1234 → values slice 3=16'h12CD the next cycle; write_strobe[3] pulses once.
- Shadowed reg 4: write 16'h0050 → values unchanged until commit. Then pulse commit → values slice 4=16'h0050. Write 16'h0060 on the same edge as commit → live=16'h0060.
- Write 16'hFFFF to RO reg 1 with hw_values slice 1=16'h0123 → read returns 16'h0123, no strobe, ack given.
- Hold en high for 5 cycles with rd=1 → exactly one ack; the next access is accepted only after en drops.
- Assert reset mid-ACK → ack, data_oe and write_strobe drop immediately and registers return to RESET_VALUE; addr 200 read afterwards → data_out=0 with ack.

Source files
------------

// File: rtl/cc_regs_pkg.sv
// Shared definitions for the ChronoCube control-register bank:
// bus FSM encoding, display register map and default masks.
package cc_regs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACK     = 2'd1,
      ST_RELEASE = 2'd2
   } bus_state_t;

   localparam int MAIN_CTRL = 0;
   localparam int X_POS     = 1;
   localparam int Y_POS     = 2;
   localparam int X_OFFSET  = 3;
   localparam int Y_OFFSET  = 4;

   // Beam position is read back from the video logic; scroll offsets must not tear.
   localparam logic [15:0] DISPLAY_RO_MASK     = (16'd1 << X_POS) | (16'd1 << Y_POS);
   localparam logic [15:0] DISPLAY_SHADOW_MASK = (16'd1 << X_OFFSET) | (16'd1 << Y_OFFSET);

endpackage

// File: rtl/cc_byte_reg.sv
// One register with per-byte write enables and async active-low reset;
// the merged next value is exported so a shadow copy can forward it.
module cc_byte_reg
   import cc_regs_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DATA_WIDTH-1:0]   d,
   output logic [DATA_WIDTH-1:0]   nxt,
   output logic [DATA_WIDTH-1:0]   q
);

   always_comb begin
      nxt = q;
      for (int k = 0; k < DATA_WIDTH/8; k++) begin
         if (be[k]) nxt[8*k +: 8] = d[8*k +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= RESET_VALUE;
      else        q <= nxt;
   end

endmodule

// File: rtl/cc_register_bank.sv
// ChronoCube MPU-bus control-register bank with request/ack handshake.
// Define CC_REG_SHADOW_EN to build staging registers and the commit path.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for en & (rd | wr); access performed on accept edge
// ST_ACK     | ack high for exactly this cycle, read data valid
// ST_RELEASE | waiting for en to drop so one request gives one access
module cc_register_bank
   import cc_regs_pkg::*;
#(
   parameter int                                NUM_REGS    = 16,
   parameter int                                ADDR_WIDTH  = 8,
   parameter int                                DATA_WIDTH  = 16,
   parameter logic [NUM_REGS-1:0]               RO_MASK     = '0,
   parameter logic [NUM_REGS-1:0]               SHADOW_MASK = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic                           rd,
   input  logic                           wr,
   input  logic [DATA_WIDTH/8-1:0]        be,
   input  logic [ADDR_WIDTH-1:0]          addr,
   input  logic [DATA_WIDTH-1:0]          data_in,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           data_oe,
   output logic                           ack,
   input  logic                           commit,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_values,
   output logic [NUM_REGS*DATA_WIDTH-1:0] values,
   output logic [NUM_REGS-1:0]            write_strobe
);

   localparam int BYTES = DATA_WIDTH / 8;

   bus_state_t              state;
   logic                    accept;
   logic [NUM_REGS-1:0]     wr_sel;
   logic [DATA_WIDTH-1:0]   rd_val;
   logic [DATA_WIDTH-1:0]   live_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   read_q [NUM_REGS];
   logic                    unused_ok;

   assign accept    = (state == ST_IDLE) && en && (rd || wr);
   assign unused_ok = ^{commit, SHADOW_MASK, hw_values};

   // Out-of-range addresses match no register: no write, read data zero.
   always_comb begin
      wr_sel = '0;
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr == ADDR_WIDTH'(i)) begin
            wr_sel[i] = accept && wr && !rd && !RO_MASK[i];
            rd_val    = read_q[i];
         end
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      localparam logic [DATA_WIDTH-1:0] RV = RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH];

      if (RO_MASK[i]) begin : g_ro
         assign live_q[i] = hw_values[i*DATA_WIDTH +: DATA_WIDTH];
         assign read_q[i] = live_q[i];
      end
`ifdef CC_REG_SHADOW_EN
      else if (SHADOW_MASK[i]) begin : g_shadow
         logic [BYTES-1:0]      wr_be;
         logic [DATA_WIDTH-1:0] stage_nxt;
         logic [DATA_WIDTH-1:0] stage_q;
         logic [DATA_WIDTH-1:0] unused_live_nxt;

         assign wr_be = wr_sel[i] ? be : '0;

         cc_byte_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE(RV)) u_stage (
            .clk   (clk),
            .reset (reset),
            .be    (wr_be),
            .d     (data_in),
            .nxt   (stage_nxt),
            .q     (stage_q)
         );

         // Live takes the merged staging value so a write on the commit edge lands this frame.
         cc_byte_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE(RV)) u_live (
            .clk   (clk),
            .reset (reset),
            .be    ({BYTES{commit}}),
            .d     (stage_nxt),
            .nxt   (unused_live_nxt),
            .q     (live_q[i])
         );

         assign read_q[i] = stage_q;
      end
`endif
      else begin : g_live
         logic [BYTES-1:0]      wr_be;
         logic [DATA_WIDTH-1:0] unused_live_nxt;

         assign wr_be = wr_sel[i] ? be : '0;

         cc_byte_reg #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE(RV)) u_live (
            .clk   (clk),
            .reset (reset),
            .be    (wr_be),
            .d     (data_in),
            .nxt   (unused_live_nxt),
            .q     (live_q[i])
         );

         assign read_q[i] = live_q[i];
      end

      assign values[i*DATA_WIDTH +: DATA_WIDTH] = live_q[i];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         ack          <= 1'b0;
         data_oe      <= 1'b0;
         data_out     <= '0;
         write_strobe <= '0;
      end else begin
         ack          <= 1'b0;
         write_strobe <= '0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state        <= ST_ACK;
                  ack          <= 1'b1;
                  data_oe      <= rd;
                  data_out     <= (rd && !wr) ? rd_val : '0;
                  write_strobe <= wr_sel;
               end
            end
            ST_ACK: state <= ST_RELEASE;
            ST_RELEASE: begin
               if (!en) begin
                  state   <= ST_IDLE;
                  data_oe <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cc_register_bank.sv
// Directed self-checking bench for cc_register_bank (display-style masks:
// reg 1 read-only, reg 4 shadowed when CC_REG_SHADOW_EN is defined).
module tb_cc_register_bank;

   localparam int NR = 16;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam logic [NR-1:0]    RO  = 16'h0002;
   localparam logic [NR-1:0]    SH  = 16'h0010;
   localparam logic [NR*DW-1:0] RV  = (256'h0808 << 128) | (256'h0040 << 64)
                                    | (256'h1234 << 48) | 256'h0003;

   logic              clk = 1'b0;
   logic              reset;
   logic              en, rd, wr, commit;
   logic [DW/8-1:0]   be;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     data_in, data_out;
   logic              data_oe, ack;
   logic [NR*DW-1:0]  hw_values, values;
   logic [NR-1:0]     write_strobe;

   int checks = 0;
   int errors = 0;
   int n_ack;

   always #5 clk = ~clk;

   cc_register_bank #(
      .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .RO_MASK(RO), .SHADOW_MASK(SH), .RESET_VALUE(RV)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .rd(rd), .wr(wr), .be(be),
      .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
      .ack(ack), .commit(commit), .hw_values(hw_values), .values(values),
      .write_strobe(write_strobe)
   );

   function automatic logic [DW-1:0] val(input int i);
      return values[i*DW +: DW];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request at the falling edge; returns just after the accept edge (ACK cycle).
   task automatic req(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW/8-1:0] b, input logic c);
      @(negedge clk);
      en = 1'b1; rd = r; wr = w; addr = a; data_in = d; be = b; commit = c;
      @(posedge clk); #1;
   endtask

   task automatic finish_req();
      @(negedge clk);
      en = 1'b0; rd = 1'b0; wr = 1'b0; commit = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; rd = 1'b0; wr = 1'b0; commit = 1'b0;
      be = '0; addr = '0; data_in = '0;
      hw_values = (256'h0123 << 16) | (256'hBEEF << 32);

      #12;
      chk("rst_ack", ack, 0);
      chk("rst_oe", data_oe, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_strobe", write_strobe, 0);
      chk("rst_val0", val(0), 16'h0003);
      chk("rst_val3", val(3), 16'h1234);
      chk("ro_passthru", val(1), 16'h0123);

      // Read request held across reset release.
      en = 1'b1; rd = 1'b1; addr = 8'd0; be = 2'b11;
      @(negedge clk); reset = 1'b1;
      #1;
      chk("pre_accept_ack", ack, 0);
      @(posedge clk); #1;
      chk("rd0_ack", ack, 1);
      chk("rd0_data", data_out, 16'h0003);
      chk("rd0_oe_ack", data_oe, 1);
      @(negedge clk); en = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      chk("rd0_ack_drop", ack, 0);
      chk("rd0_oe_release", data_oe, 1);
      @(posedge clk); #1;
      chk("rd0_oe_idle", data_oe, 0);

      // Byte-enabled write to plain register.
      req(1'b0, 1'b1, 8'd3, 16'hABCD, 2'b01, 1'b0);
      chk("wr3_ack", ack, 1);
      chk("wr3_val", val(3), 16'h12CD);
      chk("wr3_strobe", write_strobe, 16'h0008);
      @(posedge clk); #1;
      chk("wr3_strobe_once", write_strobe, 0);
      finish_req();

      // Shadowed register.
      req(1'b0, 1'b1, 8'd4, 16'h0050, 2'b11, 1'b0);
      chk("wr4_strobe", write_strobe, 16'h0010);
`ifdef CC_REG_SHADOW_EN
      chk("wr4_live_hold", val(4), 16'h0040);
`else
      chk("wr4_live_direct", val(4), 16'h0050);
`endif
      finish_req();
      req(1'b1, 1'b0, 8'd4, 16'h0000, 2'b11, 1'b0);
      chk("rd4_data", data_out, 16'h0050);
      finish_req();
      @(negedge clk); commit = 1'b1;
      @(posedge clk); #1;
      chk("commit4_val", val(4), 16'h0050);
      @(negedge clk); commit = 1'b0;
      req(1'b0, 1'b1, 8'd4, 16'h0060, 2'b11, 1'b1);
      chk("wr_commit4_val", val(4), 16'h0060);
      finish_req();
      chk("after_commit4_val", val(4), 16'h0060);

      // Read-only register write is ignored.
      req(1'b0, 1'b1, 8'd1, 16'hFFFF, 2'b11, 1'b0);
      chk("wr1_ack", ack, 1);
      chk("wr1_strobe", write_strobe, 0);
      finish_req();
      req(1'b1, 1'b0, 8'd1, 16'h0000, 2'b11, 1'b0);
      chk("rd1_data", data_out, 16'h0123);
      finish_req();

      // Request held high for five cycles gives one ack.
      @(negedge clk); en = 1'b1; rd = 1'b1; addr = 8'd3;
      n_ack = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ack) n_ack++;
      end
      chk("hold_one_ack", n_ack, 1);
      @(negedge clk); en = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      chk("hold_oe_idle", data_oe, 0);
      req(1'b1, 1'b0, 8'd3, 16'h0000, 2'b11, 1'b0);
      chk("rd3_reaccept_ack", ack, 1);
      chk("rd3_data", data_out, 16'h12CD);
      finish_req();

      // rd and wr together.
      req(1'b1, 1'b1, 8'd3, 16'h0000, 2'b11, 1'b0);
      chk("rdwr_ack", ack, 1);
      chk("rdwr_dout", data_out, 0);
      chk("rdwr_strobe", write_strobe, 0);
      chk("rdwr_val3", val(3), 16'h12CD);
      finish_req();

      // Out-of-range access.
      req(1'b1, 1'b0, 8'd16, 16'h0000, 2'b11, 1'b0);
      chk("oor_rd_ack", ack, 1);
      chk("oor_rd_dout", data_out, 0);
      finish_req();
      req(1'b0, 1'b1, 8'd16, 16'h7777, 2'b11, 1'b0);
      chk("oor_wr_strobe", write_strobe, 0);
      chk("oor_wr_val0", val(0), 16'h0003);
      finish_req();

      // Reset during ACK.
      req(1'b0, 1'b1, 8'd3, 16'h5555, 2'b11, 1'b0);
      chk("wr3b_val", val(3), 16'h5555);
      finish_req();
      req(1'b1, 1'b0, 8'd0, 16'h0000, 2'b11, 1'b0);
      chk("rd0b_oe", data_oe, 1);
      #2 reset = 1'b0;
      en = 1'b0; rd = 1'b0;
      #1;
      chk("midack_ack", ack, 0);
      chk("midack_oe", data_oe, 0);
      chk("midack_strobe", write_strobe, 0);
      chk("midack_dout", data_out, 0);
      chk("midack_val3", val(3), 16'h1234);
      chk("midack_val4", val(4), 16'h0040);
      @(negedge clk); reset = 1'b1;
      req(1'b1, 1'b0, 8'd200, 16'h0000, 2'b11, 1'b0);
      chk("rd200_ack", ack, 1);
      chk("rd200_dout", data_out, 0);
      finish_req();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
